// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and types for the 4-requester round-robin arbiter.
//   SEL_W         : width of a requester index
//   NUM_REQ       : number of requesters
//   RESET_PTR_DEF : default highest-priority requester after reset
package mux4_rr_arbiter_pkg;

  localparam int SEL_W   = 2;
  localparam int NUM_REQ = 4;

  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [NUM_REQ-1:0] req_vec_t;

  localparam sel_t RESET_PTR_DEF = 2'd0;

  // Result of one round-robin pick.
  typedef struct packed {
    sel_t g;    // winning index
    logic any;  // at least one requester valid
  } pick_t;

  // One-hot vector with bit i set.
  function automatic req_vec_t onehot(input sel_t i);
    req_vec_t v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between four requesters, the arbiter and one consumer.
//   req_valid/req_data0..3/req_ready : per-requester valid/ready channels
//   out_valid/out_data/out_src/out_ready : registered output channel
//   sel_dbg : combinational index of the current pick
// slave  : the arbiter side.
// master : the environment side (requesters + consumer).
interface mux4_rr_arbiter_if #(
  parameter int WIDTH = 64
);
  import mux4_rr_arbiter_pkg::*;

  req_vec_t         req_valid;
  logic [WIDTH-1:0] req_data0;
  logic [WIDTH-1:0] req_data1;
  logic [WIDTH-1:0] req_data2;
  logic [WIDTH-1:0] req_data3;
  req_vec_t         req_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  sel_t             out_src;
  logic             out_ready;
  sel_t             sel_dbg;

  modport slave (
    input  req_valid, req_data0, req_data1, req_data2, req_data3, out_ready,
    output req_ready, out_valid, out_data, out_src, sel_dbg
  );

  modport master (
    output req_valid, req_data0, req_data1, req_data2, req_data3, out_ready,
    input  req_ready, out_valid, out_data, out_src, sel_dbg
  );

endinterface

// File: rtl/mux4_rr_arbiter_pick.sv
// rr_pick4: combinational rotate-and-priority-encode.
//   req_valid : request vector
//   ptr       : index with highest priority
//   g         : first valid index scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//   any       : |req_valid; g == ptr when no request is valid
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  req_vec_t req_valid,
  input  sel_t     ptr,
  output sel_t     g,
  output logic     any
);

  sel_t idx;

  // Walk the scan order backwards so the earliest hit overwrites later ones.
  // The 2-bit add wraps naturally, which is exactly the mod-4 rotation.
  always_comb begin
    g   = ptr;
    idx = ptr;
    any = |req_valid;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = ptr + sel_t'(k);
      if (req_valid[idx]) g = idx;
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter: four valid/ready requesters share one 4:1 data
// select; the winner is registered onto a single valid/ready output.
//   clock     : rising-edge clock
//   reset     : synchronous, active-high
//   bus       : mux4_rr_arbiter_if.slave (requests, output channel, sel_dbg)
// Params: WIDTH (data width), RESET_PTR (priority index after reset).
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int   WIDTH     = 64,
  parameter sel_t RESET_PTR = RESET_PTR_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  mux4_rr_arbiter_if.slave      bus
);

  sel_t                            ptr;
  pick_t                           pick;
  logic                            out_valid;
  logic [WIDTH-1:0]                out_data;
  sel_t                            out_src;
  logic                            can_accept;
  logic                            grant;
  logic [NUM_REQ-1:0][WIDTH-1:0]   data_vec;
  logic [WIDTH-1:0]                data_sel;

  rr_pick4 u_pick (
    .req_valid (bus.req_valid),
    .ptr       (ptr),
    .g         (pick.g),
    .any       (pick.any)
  );

  assign data_vec = {bus.req_data3, bus.req_data2, bus.req_data1, bus.req_data0};

  always_comb begin
    data_sel = '0;
    case (pick.g)
      2'd0:    data_sel = data_vec[0];
      2'd1:    data_sel = data_vec[1];
      2'd2:    data_sel = data_vec[2];
      default: data_sel = data_vec[3];
    endcase
  end

  // Single pipeline register, no skid: accept only if empty or draining.
  assign can_accept = !out_valid || bus.out_ready;
  // pick.any implies req_valid[g], so a grant is always a transfer.
  assign grant      = can_accept && pick.any && !reset;

  assign bus.req_ready = grant ? onehot(pick.g) : '0;
  assign bus.sel_dbg   = pick.any ? pick.g : ptr;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_src   = out_src;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= RESET_PTR;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= data_sel;
      out_src   <= pick.g;
      ptr       <= pick.g + 2'd1;
    end else if (bus.out_ready) begin
      // Drain without refill; data/src keep their last values.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter.
module tb_mux4_rr_arbiter;
  import mux4_rr_arbiter_pkg::*;

  localparam logic [63:0] D0 = 64'h1000_0000_0000_0000;
  localparam logic [63:0] D1 = 64'h1111_0000_0000_0001;
  localparam logic [63:0] D2 = 64'hDEAD_BEEF_0000_0002;
  localparam logic [63:0] D3 = 64'h3333_0000_0000_0003;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total  = 0;

  mux4_rr_arbiter_if #(.WIDTH(64)) bus ();

  mux4_rr_arbiter #(.WIDTH(64), .RESET_PTR(2'd0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] dval(input int i);
    case (i)
      0: return D0;
      1: return D1;
      2: return D2;
      default: return D3;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b1;
    tick();
    #1;
    total++;
    if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", bus.req_ready);
    else passed++;
    bus.req_valid = 4'b0000;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 64'd0 || bus.out_src !== 2'd0)
      $display("FAIL reset_out got v=%b d=%h s=%0d exp v=0 d=0 s=0",
               bus.out_valid, bus.out_data, bus.out_src);
    else passed++;
    repeat (5) tick();
    total++;
    if (bus.req_ready !== 4'b0000 || bus.out_valid !== 1'b0 || bus.sel_dbg !== 2'd0)
      $display("FAIL idle got rdy=%b v=%b sel=%0d exp rdy=0000 v=0 sel=0",
               bus.req_ready, bus.out_valid, bus.sel_dbg);
    else passed++;
  endtask

  task automatic test_single();
    bus.req_valid = 4'b0100;
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0100 || bus.sel_dbg !== 2'd2)
      $display("FAIL single_grant got rdy=%b sel=%0d exp rdy=0100 sel=2", bus.req_ready, bus.sel_dbg);
    else passed++;
    tick();
    bus.req_valid = 4'b0000;
    #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd2 || bus.out_data !== D2)
      $display("FAIL single_out got v=%b s=%0d d=%h exp v=1 s=2 d=%h",
               bus.out_valid, bus.out_src, bus.out_data, D2);
    else passed++;
    // Pointer moved past 2; idle sel_dbg shows it.
    total++;
    if (bus.sel_dbg !== 2'd3) $display("FAIL single_ptr got=%0d exp=3", bus.sel_dbg);
    else passed++;
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== D2 || bus.out_src !== 2'd2)
      $display("FAIL drain got v=%b s=%0d d=%h exp v=0 s=2 d=%h",
               bus.out_valid, bus.out_src, bus.out_data, D2);
    else passed++;
  endtask

  task automatic test_round_robin();
    int exp_g [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (bus.req_ready !== onehot(sel_t'(exp_g[k])))
        $display("FAIL rr_grant%0d got=%b exp=%b", k, bus.req_ready, onehot(sel_t'(exp_g[k])));
      else passed++;
      if (k > 0) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_src !== sel_t'(exp_g[k-1]) ||
            bus.out_data !== dval(exp_g[k-1]))
          $display("FAIL rr_out%0d got v=%b s=%0d d=%h exp v=1 s=%0d d=%h", k,
                   bus.out_valid, bus.out_src, bus.out_data, exp_g[k-1], dval(exp_g[k-1]));
        else passed++;
      end
      tick();
    end
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd1)
      $display("FAIL rr_last got v=%b s=%0d exp v=1 s=1", bus.out_valid, bus.out_src);
    else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.req_valid = 4'b0010;
    bus.out_ready = 1'b1;
    tick();
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (bus.req_ready !== 4'b0000 || bus.out_valid !== 1'b1 ||
          bus.out_src !== 2'd1 || bus.out_data !== D1)
        $display("FAIL stall%0d got rdy=%b v=%b s=%0d d=%h exp rdy=0000 v=1 s=1 d=%h", k,
                 bus.req_ready, bus.out_valid, bus.out_src, bus.out_data, D1);
      else passed++;
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0100)
      $display("FAIL stall_release got=%b exp=0100", bus.req_ready);
    else passed++;
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd2 || bus.out_data !== D2)
      $display("FAIL stall_next got v=%b s=%0d exp v=1 s=2", bus.out_valid, bus.out_src);
    else passed++;
  endtask

  task automatic test_wrap_skip();
    // Pointer is 3 after the previous grant to 2.
    bus.req_valid = 4'b1000;
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b1000) $display("FAIL wrap_g3 got=%b exp=1000", bus.req_ready);
    else passed++;
    tick();
    bus.req_valid = 4'b0010;
    #1;
    total++;
    if (bus.req_ready !== 4'b0010) $display("FAIL skip_g1 got=%b exp=0010", bus.req_ready);
    else passed++;
    tick();
    bus.req_valid = 4'b0000;
    #1;
    total++;
    if (bus.sel_dbg !== 2'd2) $display("FAIL skip_ptr got=%0d exp=2", bus.sel_dbg);
    else passed++;
    bus.req_valid = 4'b0001;
    #1;
    total++;
    if (bus.req_ready !== 4'b0001 || bus.sel_dbg !== 2'd0)
      $display("FAIL wrap_g0 got rdy=%b sel=%0d exp rdy=0001 sel=0", bus.req_ready, bus.sel_dbg);
    else passed++;
    tick();
    total++;
    if (bus.out_src !== 2'd0 || bus.out_data !== D0 || bus.sel_dbg !== 2'd0)
      $display("FAIL wrap_out got s=%0d d=%h sel=%0d exp s=0 d=%h sel=0",
               bus.out_src, bus.out_data, bus.sel_dbg, D0);
    else passed++;
  endtask

  task automatic test_mid_reset();
    // out_valid=1 holding requester 0; stall it, then reset.
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b1111;
    reset = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0000) $display("FAIL midrst_ready got=%b exp=0000", bus.req_ready);
    else passed++;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", bus.out_valid);
    else passed++;
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0001 || bus.sel_dbg !== 2'd0)
      $display("FAIL midrst_first got rdy=%b sel=%0d exp rdy=0001 sel=0", bus.req_ready, bus.sel_dbg);
    else passed++;
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd0)
      $display("FAIL midrst_out got v=%b s=%0d exp v=1 s=0", bus.out_valid, bus.out_src);
    else passed++;
  endtask

  initial begin
    bus.req_valid = 4'b0000;
    bus.req_data0 = D0;
    bus.req_data1 = D1;
    bus.req_data2 = D2;
    bus.req_data3 = D3;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
